// File: rtl/fpadd_outq.sv
// rtl/fpadd_outq.sv - result queue between a pipelined FP adder and its consumer
//
// Purpose: DEPTH-entry first-word-fall-through queue for 64-bit adder results.
//          It raises o_stopout early enough that results still inside the
//          LAT-stage adder pipe always fit. If a result arrives while the
//          queue is full and nothing is popped, the result is dropped and
//          the sticky o_overflow flag is set.
// Ports:
//    i_clk      clock; all state changes on the rising edge
//    i_rst      asynchronous active-high reset
//    i_pushin   adder result valid on i_din this cycle
//    i_din      adder result {sign, exp[10:0], fract[51:0]}
//    o_stopout  asks the operand source to stop issuing
//    o_pushout  o_dout is valid (queue not empty)
//    o_dout     oldest stored result, 64'h0 when empty
//    i_pullin   consumer accepts o_dout this cycle
//    o_count    number of stored entries
//    o_overflow sticky: a result was dropped while the queue was full
module fpadd_outq #(
   parameter int DEPTH = 8,
   parameter int LAT   = 3
) (
   input  logic                     i_clk,
   input  logic                     i_rst,
   input  logic                     i_pushin,
   input  logic [63:0]              i_din,
   output logic                     o_stopout,
   output logic                     o_pushout,
   output logic [63:0]              o_dout,
   input  logic                     i_pullin,
   output logic [$clog2(DEPTH):0]   o_count,
   output logic                     o_overflow
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] C_FULL = (AW+1)'(DEPTH);
   localparam logic [AW:0] C_STOP = (AW+1)'(DEPTH - LAT);

   logic [63:0]   r_mem [DEPTH];
   logic [AW-1:0] r_wp;
   logic [AW-1:0] r_rp;
   logic [AW:0]   r_count;
   logic          r_overflow;

   logic w_pop;
   logic w_full;
   logic w_wr;

   assign w_full = (r_count == C_FULL);
   assign w_pop  = (r_count != '0) && i_pullin;
   // A pop in the same cycle frees a slot, so a full queue still accepts.
   assign w_wr   = i_pushin && (!w_full || w_pop);

   // Storage is not reset; only the pointers and count define validity.
   always_ff @(posedge i_clk) begin
      if (w_wr && !i_rst) begin
         r_mem[r_wp] <= i_din;
      end
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_wp       <= '0;
         r_rp       <= '0;
         r_count    <= '0;
         r_overflow <= 1'b0;
      end else begin
         if (w_wr) begin
            r_wp <= r_wp + AW'(1);
         end
         if (w_pop) begin
            r_rp <= r_rp + AW'(1);
         end
         case ({w_wr, w_pop})
            2'b10:   r_count <= r_count + (AW+1)'(1);
            2'b01:   r_count <= r_count - (AW+1)'(1);
            default: r_count <= r_count;
         endcase
         if (i_pushin && !w_wr) begin
            r_overflow <= 1'b1;
         end
      end
   end

   assign o_pushout  = (r_count != '0);
   assign o_dout     = o_pushout ? r_mem[r_rp] : 64'h0;
   // Registered count only: no combinational path from i_pushin or i_pullin.
   assign o_stopout  = (r_count >= C_STOP);
   assign o_count    = r_count;
   assign o_overflow = r_overflow;

endmodule

// File: tb/tb_fpadd_outq.sv
// tb/tb_fpadd_outq.sv - self-checking bench for fpadd_outq
module tb_fpadd_outq;

   localparam int DEPTH = 8;
   localparam int LAT   = 3;

   logic        clk;
   logic        rst;
   logic        pushin;
   logic [63:0] din;
   logic        stopout;
   logic        pushout;
   logic [63:0] dout;
   logic        pullin;
   logic [3:0]  count;
   logic        overflow;

   int          tests;
   int          fails;

   logic [63:0] q[$];
   logic        m_ovf;

   logic        pv [LAT];
   logic [63:0] pd [LAT];

   fpadd_outq #(.DEPTH(DEPTH), .LAT(LAT)) dut (
      .i_clk      (clk),
      .i_rst      (rst),
      .i_pushin   (pushin),
      .i_din      (din),
      .o_stopout  (stopout),
      .o_pushout  (pushout),
      .o_dout     (dout),
      .i_pullin   (pullin),
      .o_count    (count),
      .o_overflow (overflow)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Compare outputs with the model, apply this cycle's inputs to the model,
   // then advance one clock and settle just after the edge.
   task automatic step();
      bit pop;
      bit full;
      chk("pushout",  64'(pushout),  64'(q.size() != 0));
      chk("dout",     dout,          (q.size() != 0) ? q[0] : 64'h0);
      chk("count",    64'(count),    64'(q.size()));
      chk("stopout",  64'(stopout),  64'(q.size() >= DEPTH - LAT));
      chk("overflow", 64'(overflow), 64'(m_ovf));
      full = (q.size() == DEPTH);
      pop  = (q.size() != 0) && pullin;
      if (pop) void'(q.pop_front());
      if (pushin) begin
         if (!full || pop) q.push_back(din);
         else m_ovf = 1'b1;
      end
      @(posedge clk);
      #1;
   endtask

   // Mid-cycle reset; inputs driven during reset must be ignored.
   task automatic mid_reset();
      #3;
      rst    = 1'b1;
      pushin = 1'b1;
      pullin = 1'b1;
      din    = 64'hDEAD_BEEF_0000_0001;
      #1;
      chk("rst_count",   64'(count),    64'h0);
      chk("rst_pushout", 64'(pushout),  64'h0);
      chk("rst_dout",    dout,          64'h0);
      chk("rst_stopout", 64'(stopout),  64'h0);
      chk("rst_ovf",     64'(overflow), 64'h0);
      q.delete();
      m_ovf = 1'b0;
      @(posedge clk);
      #2;
      rst    = 1'b0;
      pushin = 1'b0;
      pullin = 1'b0;
      @(posedge clk);
      #1;
   endtask

   initial begin
      tests  = 0;
      fails  = 0;
      m_ovf  = 1'b0;
      rst    = 1'b1;
      pushin = 1'b0;
      pullin = 1'b0;
      din    = 64'h0;
      for (int i = 0; i < LAT; i++) begin
         pv[i] = 1'b0;
         pd[i] = 64'h0;
      end
      @(posedge clk);
      @(posedge clk);
      #1;
      chk("init_count",   64'(count),   64'h0);
      chk("init_pushout", 64'(pushout), 64'h0);
      chk("init_dout",    dout,         64'h0);
      rst = 1'b0;
      @(posedge clk);
      #1;

      // Single push of 1.0, visible the next cycle.
      pushin = 1'b1;
      din    = 64'h3FF0000000000000;
      step();
      pushin = 1'b0;
      chk("one_dout", dout, 64'h3FF0000000000000);
      step();
      mid_reset();

      // Fill past full with distinct values, then drain in order.
      pullin = 1'b0;
      for (int i = 0; i < DEPTH + 1; i++) begin
         pushin = 1'b1;
         din    = 64'hC000_0000_0000_0000 | 64'(i * 3 + 1);
         step();
      end
      pushin = 1'b0;
      chk("fill_count", 64'(count),    64'd8);
      chk("fill_ovf",   64'(overflow), 64'h1);
      pullin = 1'b1;
      for (int i = 0; i < DEPTH + 1; i++) step();
      pullin = 1'b0;
      mid_reset();

      // Full queue with simultaneous push/pop across pointer wrap.
      for (int i = 0; i < DEPTH; i++) begin
         pushin = 1'b1;
         din    = 64'(i);
         step();
      end
      pullin = 1'b1;
      for (int i = 0; i < 20; i++) begin
         din = 64'(100 + i);
         step();
      end
      pushin = 1'b0;
      chk("stream_ovf", 64'(overflow), 64'h0);
      for (int i = 0; i < DEPTH + 1; i++) step();
      pullin = 1'b0;

      // Reset with 4 entries stored, then one push after reset.
      for (int i = 0; i < 4; i++) begin
         pushin = 1'b1;
         din    = 64'h8000_0000_0000_0000 + 64'(i);
         step();
      end
      pushin = 1'b0;
      mid_reset();
      pushin = 1'b1;
      din    = 64'h4000_0000_0000_0000;
      step();
      pushin = 1'b0;
      chk("post_rst_dout", dout, 64'h4000_0000_0000_0000);
      pullin = 1'b1;
      step();

      // Zero result pushed into an empty queue with pullin held.
      pushin = 1'b1;
      din    = 64'h0;
      step();
      pushin = 1'b0;
      chk("zero_pushout", 64'(pushout), 64'h1);
      chk("zero_dout",    dout,         64'h0);
      step();
      chk("zero_after",   64'(pushout), 64'h0);
      chk("zero_count",   64'(count),   64'h0);
      step();
      pullin = 1'b0;

      // Random traffic with a source that honours stopout through a LAT pipe.
      for (int c = 0; c < 10000; c++) begin
         bit issue;
         issue  = !stopout && ($urandom_range(0, 99) < 70);
         pushin = pv[LAT-1];
         din    = pd[LAT-1];
         pullin = ($urandom_range(0, 99) < 45);
         step();
         for (int k = LAT - 1; k > 0; k--) begin
            pv[k] = pv[k-1];
            pd[k] = pd[k-1];
         end
         pv[0] = issue;
         pd[0] = {$urandom, $urandom};
      end
      pushin = 1'b0;
      chk("rand_ovf", 64'(overflow), 64'h0);
      pullin = 1'b1;
      for (int i = 0; i < DEPTH + 1; i++) step();
      chk("rand_empty", 64'(count), 64'h0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/fpadd_outq.md
FPADD_OUTQ -- requirements
Module: fpadd_outq

Interface
REQ-001 Parameter DEPTH, default 8: number of 64-bit result entries; SHALL be a power of 2, minimum 4.
REQ-002 Parameter LAT, default 3: adder pipeline depth, equal to the maximum number of results in flight after the source stops; SHALL satisfy LAT < DEPTH.
REQ-003 clk  input  1: single clock; all state changes on the rising edge.
REQ-004 rst  input  1: reset, asynchronous and active-high.
REQ-005 pushin  input  1: a valid adder result is present on din this cycle; driven from the adder pushout.
REQ-006 din  input  64: adder result {sign, exp[10:0], fract[51:0]}; stored unmodified.
REQ-007 stopout  output  1: tells the operand source to stop issuing pushin to the adder.
REQ-008 pushout  output  1: dout holds a valid result (queue not empty).
REQ-009 dout  output  64: oldest stored result (first-word-fall-through).
REQ-010 pullin  input  1: consumer accepts dout this cycle.
REQ-011 count  output  log2(DEPTH)+1: number of stored entries.
REQ-012 overflow  output  1: sticky flag; a result was dropped because the queue was full.

Function
REQ-013 Storage SHALL be a DEPTH-entry circular buffer with write pointer wp and read pointer rp, each log2(DEPTH) bits, wrapping from DEPTH-1 to 0.
REQ-014 Write accepted: pushin=1 and (count<DEPTH or pop this cycle); din is written at wp and wp advances by 1.
REQ-015 Pop: pushout=1 and pullin=1; rp advances by 1. pullin while empty SHALL have no effect.
REQ-016 Count update per cycle: +1 on write only, -1 on pop only, unchanged on write with pop or on neither.
REQ-017 When full, a simultaneous push and pop SHALL both occur; count stays DEPTH and no data is lost.
REQ-018 When full, push without pop SHALL drop din, leave count, wp, and contents unchanged, and set overflow to 1 on the next edge.
REQ-019 When empty, a simultaneous push and pop is impossible because pushout=0; the push is stored and pushout goes to 1 the next cycle, giving 1-cycle write-to-read latency.
REQ-020 pushout SHALL equal (count != 0), and dout SHALL equal the entry at rp when pushout=1 and 64'h0 otherwise.
REQ-021 stopout SHALL equal (count >= DEPTH-LAT) and is derived from registered count only, with no combinational path from pushin or pullin.
REQ-022 With the source honouring stopout, at most LAT further results arrive after stopout rises; REQ-021 guarantees these fit, so overflow SHALL never set in compliant operation.
REQ-023 Once set, overflow SHALL remain 1 until reset.
REQ-024 Entry contents SHALL be bit-exact; zero results (64'h0) and negative zeros are stored like any other value.

Reset
REQ-025 While rst=1: count=0, wp=0, rp=0, pushout=0, dout=64'h0, stopout=0, overflow=0; storage contents need not be cleared.
REQ-026 rst asserted mid-operation SHALL discard all stored entries immediately (asynchronously); pushin and pullin during reset SHALL be ignored.
REQ-027 The first write after rst deasserts SHALL go to entry 0.

Verification
REQ-028 Reset, then push 64'h3FF0000000000000 for one cycle with pullin=0 -> next cycle pushout=1, dout=64'h3FF0000000000000, count=1.
REQ-029 With pullin=0, push DEPTH=8 distinct values -> stopout=1 from count=5 onward, count=8; a 9th push sets overflow=1 and count stays 8; draining returns exactly the first 8 values in order.
REQ-030 Fill to 8, then hold pushin=1 and pullin=1 for 20 cycles with incrementing data -> count stays 8, overflow=0, output order is strictly FIFO across pointer wrap.
REQ-031 Apply random pushin/pullin for 10k cycles, with the source model issuing only while stopout=0 and a 3-cycle pipe -> overflow=0, and output sequence equals input sequence.
REQ-032 Fill with 4 entries, assert rst for one cycle mid-clock -> count=0, pushout=0, dout=0 immediately; the next push appears at dout one cycle later.
REQ-033 Empty queue, pullin=1 held, single push of 64'h0 -> pushout=1 for exactly one cycle with dout=64'h0, then count=0.
